tpu_host_seq: RTL and testbench

TPU_HOST_SEQ -- requirements
Module: tpu_host_seq

---
 rtl/tpu_host_pkg.sv | 24 ++
 rtl/tpu_res_buf.sv | 53 +++++
 rtl/tpu_host_seq.sv | 141 ++++++++++++++
 tb/tb_tpu_host_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_host_pkg.sv
// Shared types and constants for the TPU host sequencer.
// Bit positions refer to the TPU bidir input/output buses.
package tpu_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StRead,
    StDrain,
    StErr
  } state_e;

  localparam int unsigned LOAD_EN   = 0;
  localparam int unsigned SEL_B     = 1;
  localparam int unsigned IDX_LSB   = 2;
  localparam int unsigned START     = 4;
  localparam int unsigned RES_VALID = 7;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_NUM_ELEMS      = 4;

endpackage

// File: rtl/tpu_res_buf.sv
// Small byte FIFO holding the TPU result bytes until the host drains them.
module tpu_res_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_wr, do_pop;

  assign do_wr   = wr_en && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tpu_host_seq.sv
// Host-side sequencer: streams A/B operands into the TPU, starts it, collects the
// 2x2 16-bit result and hands it back to the host byte by byte.
module tpu_host_seq import tpu_host_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned NUM_ELEMS      = DEF_NUM_ELEMS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [7:0] tpu_ui_in,
  output logic [7:0] tpu_uio_in,
  input  logic [7:0] tpu_uo_out,
  input  logic [7:0] tpu_uio_out,
  output logic       busy,
  output logic       err
);

  localparam int unsigned NBytes = 2 * NUM_ELEMS;
  localparam int unsigned CntW   = $clog2(NBytes) + 1;
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BufCw  = $clog2(NBytes) + 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, idx_full;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              in_ready_q, in_ready_d;
  logic [7:0]        ui_q, ui_d, uio_q, uio_d;
  logic              hs, buf_wr, buf_pop, buf_empty;
  logic [BufCw-1:0]  buf_count;
  logic [7:0]        buf_rdata;

  assign hs        = in_valid && in_ready_q;
  assign idx_full  = cnt_q % CntW'(NUM_ELEMS);
  assign res_valid = (state_q == StDrain) && !buf_empty;
  assign buf_pop   = res_valid && res_ready;
  assign res_data  = res_valid ? buf_rdata : 8'h00;
  assign in_ready  = in_ready_q;
  assign tpu_ui_in  = ui_q;
  assign tpu_uio_in = uio_q;
  assign busy      = (state_q != StIdle);
  assign err       = (state_q == StErr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    buf_wr  = 1'b0;
    ui_d    = ui_q;
    uio_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          state_d = StLoad;
          cnt_d   = CntW'(1);
        end
      end
      StLoad: begin
        if (hs) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(NBytes)) state_d = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
        cnt_d   = '0;
        tmo_d   = '0;
      end
      StWait: begin
        // The first result byte is presented together with result_valid.
        if (tpu_uio_out[RES_VALID]) begin
          buf_wr  = 1'b1;
          state_d = StRead;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
          if (tmo_d == TmoW'(TIMEOUT_CYCLES)) state_d = StErr;
        end
      end
      StRead: begin
        buf_wr = 1'b1;
        if (buf_count == BufCw'(NBytes - 1)) state_d = StDrain;
      end
      StDrain: begin
        if (buf_pop && buf_count == BufCw'(1)) state_d = StIdle;
      end
      StErr: state_d = StErr;
      default: state_d = StIdle;
    endcase

    // Operand bytes reach the TPU one cycle after the handshake.
    if (hs) begin
      ui_d                  = in_data;
      uio_d[LOAD_EN]        = 1'b1;
      uio_d[SEL_B]          = (cnt_q >= CntW'(NUM_ELEMS));
      uio_d[IDX_LSB +: 2]   = idx_full[1:0];
    end
    if (state_q == StStart) uio_d[START] = 1'b1;
    if (state_d == StErr) begin
      ui_d  = '0;
      uio_d = '0;
    end

    in_ready_d = (state_d == StIdle) || (state_d == StLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tmo_q      <= '0;
      in_ready_q <= 1'b0;
      ui_q       <= '0;
      uio_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      in_ready_q <= in_ready_d;
      ui_q       <= ui_d;
      uio_q      <= uio_d;
    end
  end

  tpu_res_buf #(
    .DEPTH (NBytes)
  ) u_res_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (tpu_uo_out),
    .pop     (buf_pop),
    .rd_data (buf_rdata),
    .empty   (buf_empty),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_tpu_host_seq.sv
// Scoreboard bench for tpu_host_seq with a behavioural 2x2 int8 TPU model.
module tb_tpu_host_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [7:0] tpu_ui_in, tpu_uio_in;
  logic [7:0] tpu_uo_out = 8'h00;
  logic [7:0] tpu_uio_out = 8'h00;
  logic       busy, err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] ld_q[$];

  // TPU model state
  logic [63:0] mops = '0;
  logic [63:0] rb = '0;
  int cd = 0, ph = 0;
  int ld_seen = 0, start_seen = 0, start_cyc = 0;
  bit silent = 1'b0;

  // consumer state
  bit stall_req = 1'b0, stalled_once = 1'b0;
  int stall_left = 0;

  tpu_host_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .tpu_ui_in   (tpu_ui_in),
    .tpu_uio_in  (tpu_uio_in),
    .tpu_uo_out  (tpu_uo_out),
    .tpu_uio_out (tpu_uio_out),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ops byte k (send order) at [8k +: 8]: A row-major then B row-major.
  // Result: C row-major, 16-bit little-endian, byte k at [8k +: 8].
  function automatic logic [63:0] matmul(input logic [63:0] ops);
    byte a[4], b[4];
    int s;
    logic [63:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      a[k] = ops[8*k +: 8];
      b[k] = ops[32 + 8*k +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = int'(a[2*i]) * int'(b[j]) + int'(a[2*i+1]) * int'(b[2+j]);
        r[16*(2*i+j) +: 16] = s[15:0];
      end
    end
    return r;
  endfunction

  // TPU model: records loads, answers 5 cycles after start with 8 result bytes.
  always @(negedge clk) begin
    if (rst) begin
      cd = 0;
      ph = 0;
      tpu_uo_out = 8'h00;
      tpu_uio_out = 8'h00;
    end else begin
      if (ph != 0) begin
        if (ph < 8) begin
          tpu_uo_out = rb[8*ph +: 8];
          ph++;
        end else begin
          tpu_uo_out = 8'h00;
          tpu_uio_out = 8'h00;
          ph = 0;
        end
      end
      if (cd != 0) begin
        cd--;
        if (cd == 0) begin
          rb = matmul(mops);
          tpu_uo_out = rb[7:0];
          tpu_uio_out = 8'h80;
          ph = 1;
        end
      end
      if (tpu_uio_in[0]) begin
        ld_seen++;
        mops[8*(4*int'(tpu_uio_in[1]) + int'(tpu_uio_in[3:2])) +: 8] = tpu_ui_in;
        if (ld_q.size() != 0) check("load", {tpu_uio_in[1], tpu_uio_in[3:2], tpu_ui_in},
                                    ld_q.pop_front());
        else check("load_spurious", tpu_uio_in[0], 0);
      end
      if (tpu_uio_in[4]) begin
        start_seen++;
        start_cyc = cyc;
        if (!silent) cd = 5;
      end
    end
  end

  // Result consumer: decides res_ready for the next edge, then scores the handshake.
  always @(negedge clk) begin
    if (stall_req && !stalled_once && res_valid) begin
      stalled_once = 1'b1;
      stall_left = 10;
    end
    if (stall_left > 0) begin
      res_ready = 1'b0;
      stall_left--;
      if (exp_q.size() != 0) check("stall_hold", res_data, exp_q[0]);
      check("stall_valid", res_valid, 1);
    end else begin
      res_ready = 1'b1;
    end
    if (res_valid && res_ready) begin
      if (exp_q.size() != 0) check("res_byte", res_data, exp_q.pop_front());
      else check("res_extra", res_valid, 0);
    end
  end

  task automatic send_bytes(input logic [63:0] ops, input int n, input bit gap);
    int i = 0, g = 0;
    bit tog = 1'b0;
    logic [10:0] rec;
    while (i < n && g < 400) begin
      @(negedge clk);
      in_valid = gap ? tog : 1'b1;
      tog = !tog;
      in_data = ops[8*i +: 8];
      if (in_valid && in_ready) begin
        rec[10]   = (i >= 4);
        rec[9:8]  = 2'(i % 4);
        rec[7:0]  = ops[8*i +: 8];
        ld_q.push_back(rec);
        i++;
      end
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (i < n) check("send_bound", i, n);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_ui_in"}, tpu_ui_in, 0);
    check({tag, "_uio_in"}, tpu_uio_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals(tag);
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, in_ready, 1);
  endtask

  task automatic run_txn(input string tag, input logic [63:0] ops, input bit gap);
    logic [63:0] r;
    int g = 0;
    ld_seen = 0;
    start_seen = 0;
    r = matmul(ops);
    for (int k = 0; k < 8; k++) exp_q.push_back(r[8*k +: 8]);
    send_bytes(ops, 8, gap);
    while ((busy || exp_q.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_loads"}, ld_seen, 8);
    check({tag, "_starts"}, start_seen, 1);
    check({tag, "_ldq"}, ld_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_err"}, err, 0);
    exp_q.delete();
    ld_q.delete();
  endtask

  localparam logic [63:0] OpsBasic = 64'h08070605_04030201;
  localparam logic [63:0] OpsNeg   = 64'h80808080_80808080;
  localparam logic [63:0] OpsMix   = 64'h7F03FB07_04FD02FF;

  initial begin
    int g;
    apply_reset("por");

    run_txn("basic", OpsBasic, 1'b0);
    run_txn("gap", OpsBasic, 1'b1);

    stall_req = 1'b1;
    stalled_once = 1'b0;
    run_txn("stall", OpsBasic, 1'b0);
    check("stall_done", stalled_once, 1);
    stall_req = 1'b0;

    run_txn("neg", OpsNeg, 1'b0);

    ld_seen = 0;
    send_bytes(OpsMix, 3, 1'b0);
    check("mid_busy", busy, 1);
    apply_reset("mid");
    ld_q.delete();
    run_txn("fresh", OpsMix, 1'b0);

    silent = 1'b1;
    start_seen = 0;
    send_bytes(OpsBasic, 8, 1'b0);
    g = 0;
    while (!err && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("tmo_err", err, 1);
    check("tmo_cycles", cyc - start_cyc, 64);
    check("tmo_starts", start_seen, 1);
    check("tmo_ui", tpu_ui_in, 0);
    check("tmo_uio", tpu_uio_in, 0);
    check("tmo_ready", in_ready, 0);
    check("tmo_rvalid", res_valid, 0);
    check("tmo_busy", busy, 1);
    repeat (20) @(negedge clk);
    check("tmo_sticky", err, 1);
    check("tmo_sticky_uio", tpu_uio_in, 0);
    silent = 1'b0;
    ld_q.delete();
    apply_reset("post_err");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
